// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, one SETUP/ACCESS transfer per
// grant, read data or timeout error returned to the winning port.
module apb_master_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // A tie goes to the port that did not win last; a lone request always wins.
    win       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (req0_valid || req1_valid) begin
          owner_d    = win;
          last_d     = win;
          ack_d[win] = 1'b1;
          paddr_d    = win ? req1_addr  : req0_addr;
          pwrite_d   = win ? req1_write : req0_write;
          pwdata_d   = win ? req1_wdata : req0_wdata;
          psel_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        cnt_d     = '0;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = ~pready;
          if (owner_q) rdata1_d = (pready && !pwrite_q) ? prdata : '0;
          else         rdata0_d = (pready && !pwrite_q) ? prdata : '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      ack_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign req0_ack   = ack_q[0];
  assign req1_ack   = ack_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios then randomized transfers, checked
// against a transaction-level model of arbitration, latency and read-data return.
module tb_apb_master_arb;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic        req0_write, req1_write;
  logic        req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  logic [31:0] ra[2], rwd[2];
  logic        rw[2];
  logic        last_m;
  logic [31:0] rd_m[2];
  int          vectors = 0, miscompares = 0;

  assign req0_addr  = ra[0];
  assign req1_addr  = ra[1];
  assign req0_wdata = rwd[0];
  assign req1_wdata = rwd[1];
  assign req0_write = rw[0];
  assign req1_write = rw[1];

  always #5 pclk = ~pclk;

  apb_master_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_rdata();
    chk("rdata0_hold", req0_rdata, rd_m[0]);
    chk("rdata1_hold", req1_rdata, rd_m[1]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_psel"}, {31'd0, psel}, 32'd0);
    chk({tag, "_penable"}, {31'd0, penable}, 32'd0);
    chk({tag, "_ack"}, {30'd0, req1_ack, req0_ack}, 32'd0);
    chk({tag, "_done"}, {30'd0, req1_done, req0_done}, 32'd0);
    chk_rdata();
  endtask

  // One complete arbitrated transfer; waits < 0 means the slave never answers.
  task automatic xfer(input logic v0, input logic v1, input int waits, input bit glitch,
                      input logic [31:0] rdv, input bit keep);
    logic        w, ewr, e_err;
    logic [31:0] ea, ewd, onehot;
    int          lim;
    req0_valid = v0;
    req1_valid = v1;
    w      = (v0 && v1) ? ~last_m : v1;
    last_m = w;
    ea = ra[w]; ewd = rwd[w]; ewr = rw[w];
    onehot = w ? 32'd2 : 32'd1;
    pready = glitch; prdata = $urandom;
    step();
    chk("grant_ack", {30'd0, req1_ack, req0_ack}, onehot);
    chk("setup_psel", {31'd0, psel}, 32'd1);
    chk("setup_penable", {31'd0, penable}, 32'd0);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwrite", {31'd0, pwrite}, {31'd0, ewr});
    chk("setup_pwdata", pwdata, ewd);
    chk("setup_done", {30'd0, req1_done, req0_done}, 32'd0);
    if (!keep) begin
      if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    ra[w] = $urandom; rwd[w] = $urandom; rw[w] = $urandom_range(0, 1);
    pready = glitch; prdata = $urandom;
    step();
    chk("access_ack", {30'd0, req1_ack, req0_ack}, 32'd0);
    chk("access_psel", {31'd0, psel}, 32'd1);
    chk("access_penable", {31'd0, penable}, 32'd1);
    lim = (waits < 0) ? TO : waits + 1;
    for (int k = 1; k <= lim; k++) begin
      pready = (waits >= 0) && (k == lim);
      prdata = (k == lim) ? rdv : $urandom;
      step();
      if (k < lim) begin
        chk("wait_done", {30'd0, req1_done, req0_done}, 32'd0);
        chk("wait_psel", {31'd0, psel & penable}, 32'd1);
        chk("wait_paddr", paddr, ea);
        chk("wait_pwdata", pwdata, ewd);
      end else begin
        e_err = (waits < 0);
        rd_m[w] = (e_err || ewr) ? 32'd0 : rdv;
        chk("done_pulse", {30'd0, req1_done, req0_done}, onehot);
        chk("done_err", {30'd0, req1_err, req0_err}, e_err ? onehot : 32'd0);
        chk("done_psel", {31'd0, psel | penable}, 32'd0);
        chk("hold_paddr", paddr, ea);
      end
      chk_rdata();
    end
    pready = 1'b0;
  endtask

  initial begin
    last_m = 1'b1;
    rd_m[0] = '0; rd_m[1] = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rwd[i] = '0; rw[i] = 1'b0;
    end
    step();
    step();
    chk_quiet("reset");
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    chk("reset_pwrite", {31'd0, pwrite}, 32'd0);
    chk("reset_err", {30'd0, req1_err, req0_err}, 32'd0);
    preset = 1'b1;
    step();
    chk_quiet("idle_after_reset");

    // Both requesters held valid: grants alternate starting with port 0.
    ra[0] = 32'h100; rwd[0] = 32'hA0A0A0A0; rw[0] = 1'b0;
    ra[1] = 32'h200; rwd[1] = 32'hB1B1B1B1; rw[1] = 1'b1;
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b1, 0, 1'b0, $urandom, 1'b1);

    // Single zero-wait read on port 0.
    ra[0] = 32'h10; rw[0] = 1'b0; rwd[0] = 32'h0;
    xfer(1'b1, 1'b0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("read_rdata0", req0_rdata, 32'hDEADBEEF);

    // Write on port 1 with 3 wait states.
    ra[1] = 32'h20; rw[1] = 1'b1; rwd[1] = 32'h12345678;
    xfer(1'b0, 1'b1, 3, 1'b0, 32'hFFFF0000, 1'b0);
    chk("write_rdata1", req1_rdata, 32'd0);

    // Slave never ready: timeout error on port 0.
    ra[0] = 32'h30; rw[0] = 1'b0;
    xfer(1'b1, 1'b0, -1, 1'b0, 32'h55AA55AA, 1'b0);
    chk("timeout_rdata0", req0_rdata, 32'd0);
    step();
    chk_quiet("after_timeout");

    // pready asserted during IDLE and SETUP must not end the transfer.
    ra[1] = 32'h44; rw[1] = 1'b0;
    xfer(1'b0, 1'b1, 2, 1'b1, 32'hC0FFEE11, 1'b0);

    // Asynchronous reset in the middle of ACCESS aborts without a done pulse.
    ra[0] = 32'h50; rw[0] = 1'b0; rwd[0] = 32'h77;
    req0_valid = 1'b1; req1_valid = 1'b0;
    step();
    chk("abort_ack", {31'd0, req0_ack}, 32'd1);
    step();
    chk("abort_in_access", {31'd0, penable}, 32'd1);
    #3 preset = 1'b0;
    #1;
    rd_m[0] = '0; rd_m[1] = '0;
    last_m = 1'b1;
    chk_quiet("async_reset");
    pready = 1'b1;
    step();
    chk_quiet("held_reset");
    pready = 1'b0;
    preset = 1'b1;
    xfer(1'b1, 1'b1, 1, 1'b0, 32'h0BADF00D, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int pat, r;
      pat = $urandom_range(0, 3);
      if (pat == 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk_quiet("rand_idle");
      end else begin
        for (int i = 0; i < 2; i++) begin
          ra[i] = $urandom; rwd[i] = $urandom; rw[i] = $urandom_range(0, 1);
        end
        r = $urandom_range(0, 9);
        xfer(pat[0], pat[1], (r == 0) ? -1 : r % 5, bit'($urandom_range(0, 1)),
             $urandom, 1'b0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk_quiet("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
